fcache_dm: RTL and testbench

- Parametrised direct-mapped, line-granular cache.
- Successor to the flat fcache array: adds tags, valid bits, ready/valid handshakes and a backing-memory port.
- Sits between the fetch/load unit (requester side) and main memory (mem side).
- Write-through, write-allocate; a whole line is written per access.

---
 rtl/fcache_dm.sv | 133 +++++++++++++
 tb/tb_fcache_dm.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcache_dm.sv
// fcache_dm: direct-mapped, write-through / write-allocate line cache with a backing-memory port.
// Define FCACHE_STATS_EN to add saturating read hit/miss counters (hit_count, miss_count).
module fcache_dm #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_rdata
`ifdef FCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]         state;
    logic [LINES-1:0]   valid_bits;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               accept;
    logic               hit;
    logic               wr_alloc;
    logic               fill;

    // The latched request address doubles as the memory request address.
    assign req_idx       = req_addr[INDEX_W-1:0];
    assign req_tag       = req_addr[ADDR_W-1:INDEX_W];
    assign lat_idx       = mem_req_addr[INDEX_W-1:0];
    assign lat_tag       = mem_req_addr[ADDR_W-1:INDEX_W];
    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign hit           = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
    assign wr_alloc      = accept && req_write;
    assign fill          = (state == RD_WAIT) && mem_rsp_valid;
    assign rsp_valid     = (state == RESP);
    assign mem_req_valid = (state == RD_REQ) || (state == WR_REQ);
    assign mem_req_write = (state == WR_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid_bits    <= '0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            rsp_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req_addr <= req_addr;
                        if (req_write) begin
                            mem_req_wdata        <= req_wdata;
                            valid_bits[req_idx]  <= 1'b1;
                            state                <= WR_REQ;
                        end else if (hit) begin
                            rsp_rdata <= data_mem[req_idx];
                            state     <= RESP;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                RD_REQ:  if (mem_req_ready) state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        valid_bits[lat_idx] <= 1'b1;
                        rsp_rdata           <= mem_rsp_rdata;
                        state               <= RESP;
                    end
                end
                WR_REQ:  if (mem_req_ready) state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid_bits alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= req_wdata;
        end else if (fill) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_rsp_rdata;
        end
    end

`ifdef FCACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !req_write) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_fcache_dm.sv
// Self-checking bench for fcache_dm: randomized and directed accesses against a line-residency model.
module tb_fcache_dm;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 256;
    localparam int INDEX_W = 4;
    localparam int LINES   = 1 << INDEX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_rdata;
`ifdef FCACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    always #5 clk = ~clk;

    fcache_dm #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .INDEX_W(INDEX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
`ifdef FCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: main memory contents plus which full line address each set holds.
    logic [LINE_W-1:0] mem_model [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] res_addr [LINES];
    bit                res_ok   [LINES];

    // Observations of the most recent access.
    bit                o_got;
    logic [LINE_W-1:0] o_rdata;
    int                o_cycles;
    int                o_mreqs;
    bit                o_stable;
    bit                o_busy_rdy;
    bit                o_pulse_ok;
    logic [ADDR_W-1:0] o_maddr;
    logic              o_mwrite;
    logic [LINE_W-1:0] o_mwdata;

    function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {16{a ^ 16'h5A3C}};
    endfunction

    function automatic bit predict_hit(input logic [ADDR_W-1:0] a);
        int s = int'(a) % LINES;
        return res_ok[s] && (res_addr[s] == a);
    endfunction

    task automatic model_commit(input logic [ADDR_W-1:0] a);
        int s = int'(a) % LINES;
        res_ok[s]   = 1'b1;
        res_addr[s] = a;
    endtask

    task automatic model_reset();
        for (int s = 0; s < LINES; s++) res_ok[s] = 1'b0;
    endtask

    // Drives one access and plays the memory side; caller is at posedge+1 with the DUT idle.
    task automatic run_access(input bit wr, input logic [ADDR_W-1:0] a,
                              input logic [LINE_W-1:0] d, input int stall);
        bit pend  = 1'b0;
        bit first = 1'b1;
        int stall_left = stall;
        o_got = 0; o_cycles = 0; o_mreqs = 0; o_stable = 1; o_busy_rdy = 0; o_pulse_ok = 0;
        o_maddr = '0; o_mwrite = 1'b0; o_mwdata = '0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = {8{$urandom}};
        for (int c = 0; c < 100 && !o_got; c++) begin
            o_cycles++;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (rsp_valid) begin
                o_got   = 1;
                o_rdata = rsp_rdata;
            end else begin
                if (req_ready) o_busy_rdy = 1;
                if (pend) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = mem_read(a);
                    pend = 1'b0;
                end else if (mem_req_valid) begin
                    if (first) begin
                        o_maddr = mem_req_addr; o_mwrite = mem_req_write; o_mwdata = mem_req_wdata;
                        first = 1'b0;
                    end else if (mem_req_addr !== o_maddr || mem_req_write !== o_mwrite ||
                                 mem_req_wdata !== o_mwdata) begin
                        o_stable = 0;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                        o_mreqs++;
                        if (mem_req_write) mem_model[a] = d;
                        else pend = 1'b1;
                    end
                end
                @(posedge clk); #1;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = {8{$urandom}};
        if (o_got) begin
            @(posedge clk); #1;
            o_pulse_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl actual ready=%b rsp=%b mreq=%b mwr=%b required 1 0 0 0",
                     req_ready, rsp_valid, mem_req_valid, mem_req_write);
        end
        total++;
        if (rsp_rdata !== '0 || mem_req_addr !== '0 || mem_req_wdata !== '0) begin
            bad++;
            $display("FAIL reset_data actual rdata=%h maddr=%h required zero", rsp_rdata, mem_req_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss_hit();
        logic [LINE_W-1:0] exp = 256'hA5;
        mem_model[16'h0003] = exp;
        run_access(1'b0, 16'h0003, '0, 0);
        total++;
        if (!o_got || o_rdata !== exp) begin
            bad++; $display("FAIL miss_data actual=%h required=%h got=%b", o_rdata, exp, o_got);
        end
        total++;
        if (o_mreqs != 1 || o_maddr !== 16'h0003 || o_mwrite !== 1'b0) begin
            bad++; $display("FAIL miss_memreq actual n=%0d addr=%h wr=%b required 1 0003 0", o_mreqs, o_maddr, o_mwrite);
        end
        total++;
        if (o_cycles != 3 || !o_pulse_ok) begin
            bad++; $display("FAIL miss_latency actual=%0d pulse=%b required 3 1", o_cycles, o_pulse_ok);
        end
        model_commit(16'h0003);
        run_access(1'b0, 16'h0003, '0, 0);
        total++;
        if (!o_got || o_rdata !== exp || o_mreqs != 0 || o_cycles != 1) begin
            bad++; $display("FAIL hit_read actual data=%h n=%0d lat=%0d required %h 0 1", o_rdata, o_mreqs, o_cycles, exp);
        end
    endtask

    task automatic test_write_stall();
        logic [LINE_W-1:0] d = '0;
        logic [LINE_W-1:0] prev;
        d[LINE_W-1] = 1'b1;
        prev = rsp_rdata;
        run_access(1'b1, 16'h0010, d, 4);
        total++;
        if (!o_stable || o_busy_rdy) begin
            bad++; $display("FAIL wr_stall_stable actual stable=%b ready_seen=%b required 1 0", o_stable, o_busy_rdy);
        end
        total++;
        if (o_maddr !== 16'h0010 || o_mwrite !== 1'b1 || o_mwdata !== d) begin
            bad++; $display("FAIL wr_memreq actual addr=%h wr=%b data=%h required 0010 1 %h", o_maddr, o_mwrite, o_mwdata, d);
        end
        total++;
        if (!o_got || o_cycles != 6 || !o_pulse_ok || o_rdata !== prev) begin
            bad++; $display("FAIL wr_resp actual lat=%0d pulse=%b rdata=%h required 6 1 %h", o_cycles, o_pulse_ok, o_rdata, prev);
        end
        model_commit(16'h0010);
        run_access(1'b0, 16'h0010, '0, 0);
        total++;
        if (o_mreqs != 0 || o_rdata !== d) begin
            bad++; $display("FAIL wr_readback actual n=%0d data=%h required 0 %h", o_mreqs, o_rdata, d);
        end
    endtask

    task automatic test_conflict();
        logic [ADDR_W-1:0] seq [3] = '{16'h0001, 16'h0011, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, seq[i], '0, 0);
            total++;
            if (o_mreqs != 1 || o_rdata !== mem_read(seq[i])) begin
                bad++; $display("FAIL conflict_%0d actual n=%0d data=%h required 1 %h", i, o_mreqs, o_rdata, mem_read(seq[i]));
            end
            model_commit(seq[i]);
        end
    endtask

    task automatic test_sequential();
        logic [LINE_W-1:0] top = '0;
        logic [LINE_W-1:0] d;
        logic [ADDR_W-1:0] a;
        int errs = 0;
        top[LINE_W-1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = 16'h0020 + ADDR_W'(i);
            for (int k = 0; k < 5; k++) begin
                d = top - LINE_W'(i * 5 + k);
                run_access(1'b1, a, d, 0);
                model_commit(a);
                run_access(1'b0, a, '0, 0);
                total++;
                if (o_mreqs != 0 || o_rdata !== d || !o_got) begin
                    bad++; errs++;
                    if (errs < 5)
                        $display("FAIL seq_readback addr=%h actual n=%0d data=%h required 0 %h", a, o_mreqs, o_rdata, d);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        bit wr, exp_hit;
        for (int n = 0; n < 60; n++) begin
            a = ADDR_W'($urandom_range(0, 47));
            wr = ($urandom_range(0, 2) == 0);
            d = {8{$urandom}};
            exp_hit = predict_hit(a);
            run_access(wr, a, d, $urandom_range(0, 2));
            total++;
            if (wr) begin
                if (!o_got || o_mreqs != 1 || o_mwdata !== d || o_maddr !== a || !o_pulse_ok) begin
                    bad++; $display("FAIL rnd_write addr=%h actual n=%0d wdata=%h required 1 %h", a, o_mreqs, o_mwdata, d);
                end
            end else begin
                if (!o_got || o_rdata !== mem_read(a) || o_mreqs != (exp_hit ? 0 : 1) ||
                    o_cycles != (exp_hit ? 1 : 3 + 0) && o_mreqs == 0) begin
                    bad++; $display("FAIL rnd_read addr=%h actual n=%0d data=%h required n=%0d data=%h",
                                    a, o_mreqs, o_rdata, exp_hit ? 0 : 1, mem_read(a));
                end
            end
            model_commit(a);
        end
    endtask

`ifdef FCACHE_STATS_EN
    task automatic test_stats();
        logic [ADDR_W-1:0] seq [5] = '{16'h0100, 16'h0100, 16'h0205, 16'h0205, 16'h0100};
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            bad++; $display("FAIL stats_reset actual hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, seq[i], '0, 0);
            model_commit(seq[i]);
        end
        run_access(1'b1, 16'h0307, {8{32'h1234_5678}}, 0);
        model_commit(16'h0307);
        total++;
        if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
            bad++; $display("FAIL stats_count actual hit=%0d miss=%0d required 3 2", hit_count, miss_count);
        end
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            bad++; $display("FAIL stats_rereset actual hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
    endtask
`endif

    task automatic test_reset_mid_miss();
        logic [ADDR_W-1:0] a = 16'hC0DE;
        bit seen = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 10 && !mem_req_valid; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (mem_req_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_memreq actual=%b required 1", mem_req_valid);
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_async actual ready=%b mreq=%b rsp=%b required 1 0 0", req_ready, mem_req_valid, rsp_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = {8{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midrst_late_rsp actual spurious=1 required 0");
        end
        run_access(1'b0, a, '0, 0);
        total++;
        if (o_mreqs != 1 || o_rdata !== mem_read(a)) begin
            bad++; $display("FAIL midrst_remiss actual n=%0d data=%h required 1 %h", o_mreqs, o_rdata, mem_read(a));
        end
        model_commit(a);
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_stall();
        test_conflict();
        test_sequential();
        test_random();
`ifdef FCACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
